// File: rtl/dac_pkg.sv
// Shared definitions for the quad 12-bit SPI DAC frame scheduler:
// state encoding, DAC command codes and the channel-select result type.
package dac_pkg;

    localparam int SAMPLE_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] CMD_WRITE        = 4'b0000;
    localparam logic [3:0] CMD_UPDATE       = 4'b0001;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;
    localparam logic [3:0] ADDR_ALL         = 4'b1111;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } ch_sel_t;

endpackage

// File: rtl/dac_rate_divider.sv
// Free-running sample-rate divider producing a registered one-cycle tick
// every CLK_DIV clocks, first tick CLK_DIV cycles after reset release.
module dac_rate_divider #(
    parameter int CLK_DIV = 1042
) (
    input  logic IN_CLOCK,
    input  logic IN_RESET,
    output logic OUT_TICK
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] r_cnt;
    logic        r_tick;

    always_ff @(posedge IN_CLOCK or negedge IN_RESET) begin
        if (!IN_RESET) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 16'd1;
            r_tick <= (r_cnt == LAST);
        end
    end

    assign OUT_TICK = r_tick;

endmodule

// File: rtl/dac_frame_scheduler.sv
// Per-tick snapshot of four DAC channels, issued one write-and-update command
// at a time to the SPI driver, with overrun and driver-stall detection.
module dac_frame_scheduler
    import dac_pkg::*;
#(
    parameter int CLK_DIV = 1042,
    parameter int TIMEOUT = 4096,
    parameter int NUM_CH  = 4
) (
    input  logic                         IN_CLOCK,
    input  logic                         IN_RESET,
    input  logic [NUM_CH*SAMPLE_W-1:0]   IN_SAMPLES,
    input  logic [NUM_CH-1:0]            IN_CH_ENABLE,
    input  logic                         IN_DAC_DONE,
    input  logic                         IN_FLAG_CLR,
    output logic                         OUT_DAC_START,
    output logic [3:0]                   OUT_DAC_CMD,
    output logic [3:0]                   OUT_DAC_ADDR,
    output logic [SAMPLE_W-1:0]          OUT_DAC_BITS,
    output logic                         OUT_SAMPLE_TICK,
    output logic                         OUT_BUSY,
    output logic                         OUT_OVERRUN,
    output logic                         OUT_TIMEOUT,
    output logic [1:0]                   OUT_STATE
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]    r_shadow;
    logic [NUM_CH-1:0]                  r_mask;
    logic [1:0]                         r_ptr;
    logic [TO_W-1:0]                    r_to_cnt;
    logic                               r_start;
    logic [3:0]                         r_cmd;
    logic [3:0]                         r_addr;
    logic [SAMPLE_W-1:0]                r_bits;
    logic                               r_overrun;
    logic                               r_timeout;

    logic                               w_tick;
    logic                               w_set_to;
    logic                               w_to_expire;
    ch_sel_t                            w_first;
    ch_sel_t                            w_next;

    // Lowest enabled channel at index >= from; from == NUM_CH means none.
    function automatic ch_sel_t next_ch(input logic [NUM_CH-1:0] mask,
                                        input logic [2:0] from);
        ch_sel_t res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                res.found = 1'b1;
                res.idx   = 2'(i);
            end
        end
        return res;
    endfunction

    dac_rate_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .IN_CLOCK (IN_CLOCK),
        .IN_RESET (IN_RESET),
        .OUT_TICK (w_tick)
    );

    assign w_first     = next_ch(IN_CH_ENABLE, 3'd0);
    assign w_next      = next_ch(r_mask, {1'b0, r_ptr} + 3'd1);
    assign w_to_expire = (r_to_cnt == TO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_set_to    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && w_first.found) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (IN_DAC_DONE) begin
                    w_state_nxt = w_next.found ? ST_ISSUE : ST_IDLE;
                end else if (w_to_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_set_to    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command outputs are registered from ISSUE, so START lands in the
    // first WAIT cycle and stays aligned with CMD/ADDR/BITS.
    always_ff @(posedge IN_CLOCK or negedge IN_RESET) begin
        if (!IN_RESET) begin
            r_state   <= ST_IDLE;
            r_shadow  <= '0;
            r_mask    <= '0;
            r_ptr     <= '0;
            r_to_cnt  <= '0;
            r_start   <= 1'b0;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_bits    <= '0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= (r_state == ST_ISSUE);

            if (r_state == ST_IDLE && w_tick) begin
                r_shadow <= IN_SAMPLES;
                r_mask   <= IN_CH_ENABLE;
                r_ptr    <= w_first.idx;
            end else if (r_state == ST_WAIT && IN_DAC_DONE && w_next.found) begin
                r_ptr <= w_next.idx;
            end

            if (r_state == ST_ISSUE) begin
                r_cmd    <= CMD_WRITE_UPDATE;
                r_addr   <= {2'b00, r_ptr};
                r_bits   <= r_shadow[r_ptr];
                r_to_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            // A set event outranks a simultaneous clear.
            if (w_tick && r_state != ST_IDLE) r_overrun <= 1'b1;
            else if (IN_FLAG_CLR)             r_overrun <= 1'b0;

            if (w_set_to)         r_timeout <= 1'b1;
            else if (IN_FLAG_CLR) r_timeout <= 1'b0;
        end
    end

    assign OUT_DAC_START   = r_start;
    assign OUT_DAC_CMD     = r_cmd;
    assign OUT_DAC_ADDR    = r_addr;
    assign OUT_DAC_BITS    = r_bits;
    assign OUT_SAMPLE_TICK = w_tick;
    assign OUT_BUSY        = (r_state != ST_IDLE);
    assign OUT_OVERRUN     = r_overrun;
    assign OUT_TIMEOUT     = r_timeout;
    assign OUT_STATE       = r_state;

endmodule
